// File: rtl/contador_lector_pkg.sv
// Shared definitions for the counter-readout initiator (contador_lector).
// State encoding, index width and parameter defaults live here so the top
// and its timeout sub-module agree on them.
package contador_lector_pkg;

   // Index bus width is fixed by the responder interface (up to 8 counters).
   localparam int IDX_W       = 3;

   // Default configuration of a sweep.
   localparam int NUM_CNT_DEF = 5;
   localparam int DATA_W_DEF  = 6;
   localparam int TIMEOUT_DEF = 4;

   // Sweep controller states.
   typedef enum logic [2:0] {
      IDLE_S    = 3'd0,
      WAIT_IDLE = 3'd1,
      REQ_S     = 3'd2,
      GAP_S     = 3'd3,
      DONE_S    = 3'd4
   } state_t;

endpackage

// File: rtl/contador_lector_timeout.sv
// lector_timeout: loadable / clearable down-counter used to bound how long
// the sweep waits in REQ_S for the responder. `expired` flags the last
// allowed wait cycle so the controller can abandon the index on that edge.
module lector_timeout
   import contador_lector_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic load,
   input  logic dec,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   // Load wins over clear so a GAP_S -> REQ_S hop re-arms the full budget.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (load)
         cnt_q <= CW'(TIMEOUT);
      else if (clear)
         cnt_q <= '0;
      else if (dec && (cnt_q != '0))
         cnt_q <= cnt_q - CW'(1);
   end

   // One count left means this REQ_S cycle is the last one we wait.
   assign expired = (cnt_q == CW'(1));

endmodule

// File: rtl/contador_lector.sv
// contador_lector: on `start`, walks idx 0..NUM_CNT-1 over the req/idx ->
// valid/data_in handshake, re-emits each returned count as a registered
// (out_idx, out_data) pulse, and pulses `done` at the end of the sweep.
// Indices the responder never answers are abandoned after TIMEOUT cycles
// and flagged through the sticky err_timeout.
// Optional feature: define TOTAL_SUM_EN to accumulate the captured counts on
// `total`; without it `total` is tied to zero and no adder exists.
module contador_lector
   import contador_lector_pkg::*;
#(
   parameter int NUM_CNT = NUM_CNT_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              idle,
   input  logic              valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              req,
   output logic [IDX_W-1:0]  idx,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic [DATA_W+2:0] total
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic               tmr_load, tmr_clear, tmr_dec, tmr_expired;

   // Qualified events derived from registered state and the responder.
   logic in_req, accept, capture, give_up, last_idx;

   assign in_req   = (state_q == REQ_S);
   assign accept   = (state_q == IDLE_S) && start;
   // The responder only answers while we request; valid elsewhere is noise.
   assign capture  = in_req && valid;
   // An idle drop takes priority over the timeout: that index is retried.
   assign give_up  = in_req && !valid && idle && tmr_expired;
   assign last_idx = (idx_q == IDX_W'(NUM_CNT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE_S;
      else
         state_q <= state_d;
   end

   // Next-state logic for the sweep.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE_S:
            if (start)
               state_d = idle ? REQ_S : WAIT_IDLE;
         WAIT_IDLE:
            if (idle)
               state_d = REQ_S;
         REQ_S:
            if (valid || give_up)
               state_d = last_idx ? DONE_S : GAP_S;
            else if (!idle)
               state_d = WAIT_IDLE;
         GAP_S:
            state_d = idle ? REQ_S : WAIT_IDLE;
         DONE_S:
            state_d = IDLE_S;
         default:
            state_d = IDLE_S;
      endcase
   end

   // Outputs decoded from the registered state.
   always_comb begin
      req  = (state_q == REQ_S);
      busy = (state_q != IDLE_S);
      done = (state_q == DONE_S);
   end

   // Timer control: arm on every REQ_S entry, tick on each unanswered
   // REQ_S cycle, and drop the count when the index is left or paused.
   always_comb begin
      tmr_load  = (state_d == REQ_S) && (state_q != REQ_S);
      tmr_clear = (state_q == GAP_S) ||
                  (in_req && (state_d == WAIT_IDLE));
      tmr_dec   = in_req && !valid && idle;
   end

   lector_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .load    (tmr_load),
      .dec     (tmr_dec),
      .expired (tmr_expired)
   );

   // Index register: restarts on an accepted start, advances only in GAP_S
   // so it is stable for the whole REQ_S residency (including retries).
   always_ff @(posedge clk) begin
      if (reset)
         idx_q <= '0;
      else if (accept)
         idx_q <= '0;
      else if (state_q == GAP_S)
         idx_q <= idx_q + IDX_W'(1);
   end

   assign idx = idx_q;

   // Captured-count stream: one-cycle pulse the cycle after the handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= capture;
         if (capture) begin
            out_idx  <= idx_q;
            out_data <= data_in;
         end
      end
   end

   // Sticky timeout flag, scoped to one sweep.
   always_ff @(posedge clk) begin
      if (reset)
         err_timeout <= 1'b0;
      else if (accept)
         err_timeout <= 1'b0;
      else if (give_up)
         err_timeout <= 1'b1;
   end

`ifdef TOTAL_SUM_EN
   // Running sum of captured counts; three extra bits cover eight counters.
   always_ff @(posedge clk) begin
      if (reset)
         total <= '0;
      else if (accept)
         total <= '0;
      else if (capture)
         total <= total + {3'b000, data_in};
   end
`else
   assign total = '0;
`endif

endmodule
